reg_file_seq: RTL and testbench
===============================

// Module: reg_file_seq
// PURPOSE
//  Sequencer/arbiter in front of the 8x8-bit register file's write port. On a start pulse it
//  block-loads all 8 registers from data memory at a base address, then returns the port to the core.
//  While busy it owns the write port and stalls core writes. Sits between core writeback, data memory and reg_file.
// PARAMETERS
//  ADDR_W    7  data-memory address width; base address and memory address wrap modulo 2**ADDR_W
//  NUM_REGS  8  registers loaded per sequence (counter is 3 bits, so it must be 8)
// PORTS
//  clock          in   1       single clock; all state changes on posedge
//  reset          in   1       asynchronous, active-high; clears all state
//  start          in   1       one-cycle load request, sampled at posedge
//  start_address  in   ADDR_W  memory base address, latched when start is accepted
//  busy           out  1       sequence in progress; write port owned by sequencer
//  done           out  1       one-cycle pulse after the final register write
//  mem_rd_en      out  1       memory read strobe; data returns one cycle later
//  mem_addr       out  ADDR_W  memory address
//  mem_rd_data    in   8       read data, valid the cycle after mem_rd_en
//  core_write     in   1       core writeback request
//  core_waddr     in   3       core destination register
//  core_wdata     in   8       core writeback data
//  core_stall     out  1       core write not accepted this cycle; core holds request
//  rf_write       out  1       reg_file write enable
//  rf_waddr       out  3       reg_file write address
//  rf_wdata       out  8       reg_file write data
// BEHAVIOUR
//  - Reset: state=IDLE; busy, done, mem_rd_en, rf_write, core_stall = 0; mem_addr, rf_waddr, rf_wdata = 0.
//  - States: IDLE -> LOAD (start=1) -> DRAIN (cnt==7) -> IDLE. done is registered and pulses the cycle DRAIN exits.
//  - IDLE: the core passes through. rf_write=core_write, rf_waddr=core_waddr, rf_wdata=core_wdata, core_stall=0.
//  - Start accepted in IDLE at edge T: latch base address, cnt=0, busy=1 from T.
//  - LOAD, cycles T..T+7: mem_rd_en=1, mem_addr=base+cnt (mod 2**ADDR_W), cnt increments.
//  - Writes lag reads by one cycle: in cycles T+1..T+8, rf_write=1, rf_waddr=cnt_d, rf_wdata=mem_rd_data.
//  - DRAIN is the cycle holding the write of r7. done=1 in cycle T+9; busy=0 from T+9.
//  - Sequence length: 9 busy cycles per load.
//  - busy=1: core_stall=core_write. Core write is dropped, not queued; core must hold its request.
//  - start while busy: ignored, with no effect on cnt or base.
//  - start in the same cycle as core_write in IDLE: the core write completes this cycle; the load starts next cycle.
//  - Base address wrap: base=127 gives reads at 127, 0, 1, ..., 6.
//  - reset mid-sequence: immediately returns to IDLE with outputs at reset values. Registers already written
//    keep their values. No done pulse is produced.
// CONFIGURATION
//  REG_SEQ_SPILL_EN defined: adds ports spill (in 1), rf_raddr (out 3), rf_rdata (in 8), mem_wr_en (out 1),
//    mem_wr_data (out 8), and state SPILL.
//    - spill in IDLE: for 8 cycles, rf_raddr=cnt, mem_wr_en=1, mem_addr=base+cnt, mem_wr_data=rf_rdata
//      (combinational read), then done.
//    - busy=1 throughout the spill. start and spill together: load wins.
//  REG_SEQ_SPILL_EN undefined: none of these ports or states exist; spill logic is absent.
// STRUCTURE
//  - reg_seq_pkg: typedef enum {IDLE, LOAD, DRAIN, SPILL} seq_state_t; localparams NUM_REGS=8, DATA_W=8,
//    REG_AW=3. SPILL is used only under REG_SEQ_SPILL_EN.
//  - Sub-module rf_port_mux: combinational 2:1 write-port select (sequencer vs core) plus the core_stall term.
//  - The top level holds the FSM, counter, delayed counter and latched base address.
// TESTING
//  1. reset high mid-run, then low -> all outputs 0, busy=0; done never pulses.
//  2. mem[20..27]=10..17, start with start_address=20 -> rf writes r0..r7 = 10..17 in cycles T+1..T+8;
//     done at T+9 only.
//  3. start_address=127, mem[127]=0xAA, mem[0]=0xBB -> r0=0xAA, r1=0xBB; mem_addr sequence 127, 0, ..., 6.
//  4. core_write r2=63 at T+3 of a load -> core_stall=1 and r2 ends with the memory value;
//     write retried after done -> r2=63, stall=0.
//  5. second start at T+4 -> ignored; exactly one done pulse, at T+9.
//  6. (REG_SEQ_SPILL_EN) r0..r7=1..8, spill with base=40 -> mem[40..47]=1..8; done after the 8 writes.

Source files
------------

// File: rtl/reg_seq_pkg.sv
// Shared types and sizes for the register-file load sequencer.
// Contents:
//   NUM_REGS, DATA_W, REG_AW  register-file geometry (8 x 8-bit, 3-bit address)
//   seq_state_t               sequencer states; SPILL is reached only when
//                             REG_SEQ_SPILL_EN is defined
package reg_seq_pkg;

    localparam int NUM_REGS = 8;
    localparam int DATA_W   = 8;
    localparam int REG_AW   = 3;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        SPILL
    } seq_state_t;

endpackage

// File: rtl/rf_port_mux.sv
// Write-port select in front of the register file.
// While the sequencer is busy it owns the port. A core write in that window
// is refused through core_stall, and the core holds its request until it is
// accepted. When not busy, the core request passes straight through.
// Ports:
//   busy                              sequencer owns the write port
//   seq_write/seq_waddr/seq_wdata     sequencer write request
//   core_write/core_waddr/core_wdata  core writeback request
//   rf_write/rf_waddr/rf_wdata        selected register-file write
//   core_stall                        core write not accepted this cycle
module rf_port_mux
    import reg_seq_pkg::*;
(
    input  logic              busy,
    input  logic              seq_write,
    input  logic [REG_AW-1:0] seq_waddr,
    input  logic [DATA_W-1:0] seq_wdata,
    input  logic              core_write,
    input  logic [REG_AW-1:0] core_waddr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              rf_write,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              core_stall
);

    assign rf_write   = busy ? seq_write : core_write;
    assign rf_waddr   = busy ? seq_waddr : core_waddr;
    assign rf_wdata   = busy ? seq_wdata : core_wdata;
    assign core_stall = busy & core_write;

endmodule

// File: rtl/reg_file_seq.sv
// Block-load sequencer in front of the 8x8 register file's write port.
// On start it reads NUM_REGS bytes from data memory at the given base
// address (wrapping modulo 2**ADDR_W) and writes them to r0..r7, then pulses
// done and hands the write port back to the core. Memory reads have one
// cycle of latency, so each register write trails its read by one cycle.
// Optional feature macro REG_SEQ_SPILL_EN adds a spill path that copies
// r0..r7 to memory (ports spill, rf_raddr, rf_rdata, mem_wr_en, mem_wr_data).
// Ports:
//   clock, reset (async, active-high)
//   start, start_address        load request and memory base address
//   busy, done                  sequence in progress / one-cycle completion pulse
//   mem_rd_en, mem_addr, mem_rd_data
//                               data-memory read port
//   core_write/waddr/wdata      core writeback request; core_stall refuses it
//   rf_write/waddr/wdata        register-file write port
module reg_file_seq
    import reg_seq_pkg::*;
#(
    parameter int ADDR_W   = 7,
    parameter int NUM_REGS = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_address,
`ifdef REG_SEQ_SPILL_EN
    input  logic              spill,
    output logic [REG_AW-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wr_data,
`endif
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              core_write,
    input  logic [REG_AW-1:0] core_waddr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_stall,
    output logic              rf_write,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);

    localparam logic [REG_AW-1:0] LAST = REG_AW'(NUM_REGS - 1);

    seq_state_t        state;
    logic [REG_AW-1:0] cnt;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] next_addr;

    // Write-stage registers: the register index and write strobe for the
    // data that memory returns this cycle.
    logic [REG_AW-1:0] cnt_p1;
    logic              vld_p1;

    // Address of the following access; the adder width gives the wrap.
    assign next_addr = base + ADDR_W'(cnt) + ADDR_W'(1);

`ifdef REG_SEQ_SPILL_EN
    // Spill reads the register file combinationally, so the address is the
    // live counter and the read data goes straight to memory.
    assign rf_raddr    = cnt;
    assign mem_wr_data = rf_rdata;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            base      <= '0;
            cnt_p1    <= '0;
            vld_p1    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
`ifdef REG_SEQ_SPILL_EN
            mem_wr_en <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    vld_p1 <= 1'b0;
                    if (start) begin
                        state     <= LOAD;
                        base      <= start_address;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= start_address;
                    end
`ifdef REG_SEQ_SPILL_EN
                    else if (spill) begin
                        state     <= SPILL;
                        base      <= start_address;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        mem_wr_en <= 1'b1;
                        mem_addr  <= start_address;
                    end
`endif
                end
                LOAD: begin
                    // Read stage -> write stage boundary
                    cnt_p1 <= cnt;
                    vld_p1 <= 1'b1;
                    if (cnt == LAST) begin
                        state     <= DRAIN;
                        mem_rd_en <= 1'b0;
                        mem_addr  <= '0;
                    end else begin
                        cnt      <= cnt + REG_AW'(1);
                        mem_addr <= next_addr;
                    end
                end
                DRAIN: begin
                    // Final register write happens this cycle.
                    state  <= IDLE;
                    vld_p1 <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                end
`ifdef REG_SEQ_SPILL_EN
                SPILL: begin
                    if (cnt == LAST) begin
                        state     <= IDLE;
                        mem_wr_en <= 1'b0;
                        mem_addr  <= '0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        cnt      <= cnt + REG_AW'(1);
                        mem_addr <= next_addr;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    rf_port_mux u_mux (
        .busy       (busy),
        .seq_write  (vld_p1),
        .seq_waddr  (cnt_p1),
        .seq_wdata  (mem_rd_data),
        .core_write (core_write),
        .core_waddr (core_waddr),
        .core_wdata (core_wdata),
        .rf_write   (rf_write),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .core_stall (core_stall)
    );

endmodule

// File: tb/tb_reg_file_seq.sv
// Directed bench for reg_file_seq with behavioural data memory and
// register file attached.
module tb_reg_file_seq;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start;
    logic [6:0] start_address;
    logic       busy, done, mem_rd_en;
    logic [6:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       core_write;
    logic [2:0] core_waddr;
    logic [7:0] core_wdata;
    logic       core_stall, rf_write;
    logic [2:0] rf_waddr;
    logic [7:0] rf_wdata;
`ifdef REG_SEQ_SPILL_EN
    logic       spill;
    logic [2:0] rf_raddr;
    logic [7:0] rf_rdata;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;
    logic [7:0] spill_mem [0:127];
`endif

    logic [7:0] mem  [0:127];
    logic [7:0] rf_m [0:7];

    int vectors    = 0;
    int miscompares = 0;
    int dones;

    reg_file_seq #(.ADDR_W(7), .NUM_REGS(8)) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .start_address (start_address),
`ifdef REG_SEQ_SPILL_EN
        .spill         (spill),
        .rf_raddr      (rf_raddr),
        .rf_rdata      (rf_rdata),
        .mem_wr_en     (mem_wr_en),
        .mem_wr_data   (mem_wr_data),
`endif
        .busy          (busy),
        .done          (done),
        .mem_rd_en     (mem_rd_en),
        .mem_addr      (mem_addr),
        .mem_rd_data   (mem_rd_data),
        .core_write    (core_write),
        .core_waddr    (core_waddr),
        .core_wdata    (core_wdata),
        .core_stall    (core_stall),
        .rf_write      (rf_write),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata)
    );

    always #5 clock = ~clock;

    // Memory returns read data one cycle after the strobe; register file
    // commits at the clock edge.
    always @(posedge clock) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
        if (rf_write)  rf_m[rf_waddr] <= rf_wdata;
`ifdef REG_SEQ_SPILL_EN
        if (mem_wr_en) spill_mem[mem_addr] <= mem_wr_data;
`endif
    end
`ifdef REG_SEQ_SPILL_EN
    assign rf_rdata = rf_m[rf_raddr];
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        start = 0; start_address = 0;
        core_write = 0; core_waddr = 0; core_wdata = 0;
        mem_rd_data = 0;
`ifdef REG_SEQ_SPILL_EN
        spill = 0;
`endif
        for (int i = 0; i < 128; i++) mem[i] = 8'(i + 100);
        for (int i = 0; i < 8; i++) begin
            mem[20 + i] = 8'(10 + i);
            rf_m[i] = 8'h00;
        end
        mem[127] = 8'hAA;
        mem[0]   = 8'hBB;
        for (int i = 1; i < 7; i++) mem[i] = 8'(8'hC0 + i);

        // Reset state
        #7;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_stall", core_stall, 0);
        chk("rst_rf_write", rf_write, 0);
        chk("rst_rf_waddr", rf_waddr, 0);
        chk("rst_rf_wdata", rf_wdata, 0);
        reset = 0;
        tick;

        // 1: reset in the middle of a load
        start = 1; start_address = 7'd20;
        tick;
        start = 0;
        tick; tick;
        reset = 1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_rd_en", mem_rd_en, 0);
        chk("midrst_addr", mem_addr, 0);
        chk("midrst_rf_write", rf_write, 0);
        chk("midrst_done", done, 0);
        #1 reset = 0;
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            tick;
            if (done) dones++;
            chk("midrst_idle_busy", busy, 0);
        end
        chk("midrst_no_done", dones, 0);

        // 2: load r0..r7 from mem[20..27]
        start = 1; start_address = 7'd20;
        tick;
        start = 0;
        chk("ld_T_busy", busy, 1);
        chk("ld_T_rd_en", mem_rd_en, 1);
        chk("ld_T_addr", mem_addr, 20);
        chk("ld_T_rf_write", rf_write, 0);
        for (int k = 1; k <= 8; k++) begin
            tick;
            chk("ld_rf_write", rf_write, 1);
            chk("ld_rf_waddr", rf_waddr, 32'(k - 1));
            chk("ld_rf_wdata", rf_wdata, 32'(10 + k - 1));
            chk("ld_busy", busy, 1);
            chk("ld_done", done, 0);
            chk("ld_rd_en", mem_rd_en, (k < 8) ? 1 : 0);
            if (k < 8) chk("ld_addr", mem_addr, 32'(20 + k));
        end
        tick;
        chk("ld_T9_done", done, 1);
        chk("ld_T9_busy", busy, 0);
        chk("ld_T9_rf_write", rf_write, 0);
        tick;
        chk("ld_T10_done", done, 0);
        for (int i = 0; i < 8; i++) chk("ld_rf_value", rf_m[i], 32'(10 + i));

        // 3: base address wraps past 127
        start = 1; start_address = 7'd127;
        tick;
        start = 0;
        chk("wrap_addr0", mem_addr, 127);
        for (int k = 1; k <= 7; k++) begin
            tick;
            chk("wrap_addr", mem_addr, 32'(k - 1));
        end
        tick; tick;
        chk("wrap_done", done, 1);
        tick;
        chk("wrap_r0", rf_m[0], 8'hAA);
        chk("wrap_r1", rf_m[1], 8'hBB);
        chk("wrap_r7", rf_m[7], 8'hC6);

        // 4: core write during a load is stalled, then retried
        start = 1; start_address = 7'd20;
        tick;
        start = 0;
        tick; tick; tick;
        core_write = 1; core_waddr = 3'd2; core_wdata = 8'd63;
        #1;
        chk("stall_T3", core_stall, 1);
        chk("stall_T3_waddr", rf_waddr, 2);
        chk("stall_T3_wdata", rf_wdata, 12);
        for (int k = 4; k <= 8; k++) begin
            tick;
            chk("stall_busy", core_stall, 1);
        end
        tick;
        chk("retry_stall", core_stall, 0);
        chk("retry_r2_before", rf_m[2], 12);
        chk("retry_rf_write", rf_write, 1);
        chk("retry_rf_waddr", rf_waddr, 2);
        chk("retry_rf_wdata", rf_wdata, 63);
        tick;
        core_write = 0;
        chk("retry_r2_after", rf_m[2], 63);

        // 5: second start while busy is ignored
        start = 1; start_address = 7'd20;
        tick;
        start = 0;
        dones = 0;
        for (int k = 1; k <= 12; k++) begin
            if (k == 4) begin
                start = 1; start_address = 7'd50;
            end
            tick;
            start = 0;
            if (done) dones++;
            chk("restart_done", done, (k == 9) ? 1 : 0);
            if (k == 5) begin
                chk("restart_addr", mem_addr, 25);
                chk("restart_waddr", rf_waddr, 4);
            end
        end
        chk("restart_one_done", dones, 1);
        chk("restart_idle", busy, 0);

`ifdef REG_SEQ_SPILL_EN
        // 6: spill r0..r7 = 1..8 to mem[40..47]
        for (int i = 0; i < 8; i++) begin
            core_write = 1; core_waddr = 3'(i); core_wdata = 8'(i + 1);
            tick;
        end
        core_write = 0;
        spill = 1; start_address = 7'd40;
        tick;
        spill = 0;
        chk("spill_busy", busy, 1);
        for (int k = 1; k <= 8; k++) begin
            tick;
            chk("spill_done", done, (k == 8) ? 1 : 0);
        end
        for (int i = 0; i < 8; i++) chk("spill_mem", spill_mem[40 + i], 32'(i + 1));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
